// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: phase accumulator, glitch-free
// config handoff at phase wrap, and a 3-stage waveform/scale/output pipeline.
module dds_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               I_en,
  input  logic               I_cfg_valid,
  output logic               I_cfg_ready,
  input  logic [PHASE_W-1:0] I_cfg_ftw,
  input  logic [1:0]         I_cfg_wave,
  input  logic [8:0]         I_cfg_amp,
  output logic [DATA_W-1:0]  O_data,
  output logic               O_valid,
  output logic               O_wrap
);

  localparam int                PROD_W    = DATA_W + 10;
  localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [8:0]        AMP_UNITY = 9'd256;
  localparam logic [1:0]        WAVE_SAW  = 2'd0;
  localparam logic [1:0]        WAVE_TRI  = 2'd1;
  localparam logic [1:0]        WAVE_SQR  = 2'd2;
  localparam logic [1:0]        WAVE_DC   = 2'd3;

  function automatic logic [8:0] sat_amp(input logic [8:0] amp);
    return (amp > AMP_UNITY) ? AMP_UNITY : amp;
  endfunction

  function automatic logic [DATA_W-1:0] scale_out(input logic signed [PROD_W-1:0] prod);
    return DATA_W'(prod >>> 8) ^ MIDSCALE;
  endfunction

  // top holds phase[PHASE_W-1 -: DATA_W+1]; top[DATA_W] is the half-period flag
  function automatic logic [DATA_W-1:0] raw_sample(input logic [DATA_W:0] top,
                                                   input logic [1:0]      wave);
    logic [DATA_W-1:0] r;
    case (wave)
      WAVE_SAW: r = top[DATA_W -: DATA_W];
      WAVE_TRI: r = top[DATA_W] ? ~top[DATA_W-1:0] : top[DATA_W-1:0];
      WAVE_SQR: r = top[DATA_W] ? '0 : '1;
      WAVE_DC:  r = MIDSCALE;
      default:  r = MIDSCALE;
    endcase
    return r;
  endfunction

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] ftw_act;
  logic [1:0]         wave_act;
  logic [8:0]         amp_act;
  logic [PHASE_W-1:0] ftw_pend;
  logic [1:0]         wave_pend;
  logic [8:0]         amp_pend;
  logic               pending_full;

  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               accept;
  logic               apply;

  logic [DATA_W-1:0]  r_p0;
  logic [8:0]         amp_p0;
  logic               vld_p0;
  logic signed [PROD_W-1:0] s_ext_p0;
  logic signed [PROD_W-1:0] a_ext_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic               vld_p1;
  logic               vld_p2;

  assign sum         = {1'b0, phase} + {1'b0, ftw_act};
  assign carry       = I_en & sum[PHASE_W];
  assign accept      = I_cfg_valid & ~pending_full;
  // A stopped accumulator never wraps, so a zero ftw takes new config immediately
  assign apply       = pending_full & (carry | (ftw_act == '0));
  assign I_cfg_ready = ~pending_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      ftw_act      <= '0;
      wave_act     <= WAVE_DC;
      amp_act      <= AMP_UNITY;
      pending_full <= 1'b0;
      O_wrap       <= 1'b0;
    end else begin
      if (I_en) begin
        phase <= sum[PHASE_W-1:0];
      end
      O_wrap <= carry;
      if (apply) begin
        ftw_act      <= ftw_pend;
        wave_act     <= wave_pend;
        amp_act      <= amp_pend;
        pending_full <= 1'b0;
      end else if (accept) begin
        pending_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ftw_pend  <= I_cfg_ftw;
      wave_pend <= I_cfg_wave;
      amp_pend  <= I_cfg_amp;
    end
  end

  // Stage p0: waveform lookup, amplitude travels alongside its sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0   <= MIDSCALE;
      amp_p0 <= AMP_UNITY;
      vld_p0 <= 1'b0;
    end else if (I_en) begin
      r_p0   <= raw_sample(phase[PHASE_W-1 -: DATA_W+1], wave_act);
      amp_p0 <= sat_amp(amp_act);
      vld_p0 <= 1'b1;
    end
  end

  assign s_ext_p0 = {{10{~r_p0[DATA_W-1]}}, ~r_p0[DATA_W-1], r_p0[DATA_W-2:0]};
  assign a_ext_p0 = {{(DATA_W+1){1'b0}}, amp_p0};

  // Stage p1: signed multiply at full width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (I_en) begin
      prod_p1 <= s_ext_p0 * a_ext_p0;
      vld_p1  <= vld_p0;
    end
  end

  // Stage p2: shift back to unity scale and return to offset binary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O_data <= MIDSCALE;
      vld_p2 <= 1'b0;
    end else if (I_en) begin
      O_data <= scale_out(prod_p1);
      vld_p2 <= vld_p1;
    end
  end

  assign O_valid = vld_p2;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: directed scenarios plus randomized traffic against a
// cycle-level arithmetic model of phase, config handoff and sample values.
module tb_dds_wave_gen;

  localparam int PW = 32;
  localparam int DW = 14;
  localparam longint unsigned MOD = 64'd1 << PW;
  localparam int MID = 1 << (DW - 1);
  localparam int FULL = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          I_en;
  logic          I_cfg_valid;
  logic          I_cfg_ready;
  logic [PW-1:0] I_cfg_ftw;
  logic [1:0]    I_cfg_wave;
  logic [8:0]    I_cfg_amp;
  logic [DW-1:0] O_data;
  logic          O_valid;
  logic          O_wrap;

  int n_assert = 0;
  int n_fail = 0;

  longint unsigned m_phase, m_ftw, p_ftw;
  int m_wave, m_amp, p_wave, p_amp;
  bit m_pend, m_wrap;
  int hist[$];

  dds_wave_gen #(.PHASE_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .I_en(I_en),
    .I_cfg_valid(I_cfg_valid), .I_cfg_ready(I_cfg_ready),
    .I_cfg_ftw(I_cfg_ftw), .I_cfg_wave(I_cfg_wave), .I_cfg_amp(I_cfg_amp),
    .O_data(O_data), .O_valid(O_valid), .O_wrap(O_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic bound_expired(input string tag);
    n_assert++;
    n_fail++;
    $display("FAIL %s: wait bound expired, observed no qualifying cycle, expected one", tag);
  endtask

  function automatic int model_sample(longint unsigned ph, int wave, int amp);
    bit p;
    int r, t, s, a, y;
    p = ph >= (MOD >> 1);
    case (wave)
      0: r = int'(ph >> (PW - DW));
      1: begin
        t = int'((ph >> (PW - 1 - DW)) & longint'(FULL));
        r = p ? (FULL - t) : t;
      end
      2: r = p ? 0 : FULL;
      default: r = MID;
    endcase
    s = r - MID;
    a = (amp > 256) ? 256 : amp;
    y = (s * a) >>> 8;
    return (y + MID) & FULL;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ftw = 0; m_wave = 3; m_amp = 256;
    m_pend = 0; m_wrap = 0;
    hist.delete();
  endtask

  task automatic model_edge(input bit en, input bit vld, input longint unsigned ftw,
                            input int wave, input int amp);
    bit accept, cadd, apply;
    longint unsigned sum;
    accept = vld && !m_pend;
    sum = m_phase + m_ftw;
    cadd = en && (sum >= MOD);
    apply = m_pend && (cadd || m_ftw == 0);
    if (en) begin
      hist.push_back(model_sample(m_phase, m_wave, m_amp));
      m_phase = sum % MOD;
    end
    m_wrap = cadd;
    if (apply) begin
      m_ftw = p_ftw; m_wave = p_wave; m_amp = p_amp; m_pend = 0;
    end else if (accept) begin
      p_ftw = ftw % MOD; p_wave = wave & 3; p_amp = amp & 511; m_pend = 1;
    end
  endtask

  task automatic check_outputs();
    int n;
    int exp_d;
    n = hist.size();
    exp_d = (n >= 3) ? hist[n-3] : MID;
    check("data", O_data, exp_d);
    check("valid", O_valid, n >= 3);
    check("wrap", O_wrap, m_wrap);
    check("ready", I_cfg_ready, !m_pend);
  endtask

  task automatic step(input bit en, input bit vld, input longint unsigned ftw,
                      input int wave, input int amp);
    I_en = en;
    I_cfg_valid = vld;
    I_cfg_ftw = ftw[PW-1:0];
    I_cfg_wave = wave[1:0];
    I_cfg_amp = amp[8:0];
    @(posedge clk);
    model_edge(en, vld, ftw, wave, amp);
    #1;
    check_outputs();
  endtask

  // Called just after a rising edge; reset is raised between edges
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_data", O_data, MID);
    check("rst_valid", O_valid, 0);
    check("rst_wrap", O_wrap, 0);
    check("rst_ready", I_cfg_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int saw_tab[4];
    bit found;
    saw_tab[0] = 32'h0000; saw_tab[1] = 32'h1000;
    saw_tab[2] = 32'h2000; saw_tab[3] = 32'h3000;

    rst = 1'b1; I_en = 0; I_cfg_valid = 0; I_cfg_ftw = '0; I_cfg_wave = '0; I_cfg_amp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_data", O_data, MID);
    check("init_valid", O_valid, 0);
    check("init_ready", I_cfg_ready, 1);
    rst = 1'b0;

    // Saw at a quarter of the clock rate, taken while the accumulator is idle
    step(1, 1, 64'h4000_0000, 0, 256);
    check("cfg_ready_low", I_cfg_ready, 0);
    step(1, 0, 0, 0, 0);
    check("cfg_applied_next", I_cfg_ready, 1);
    for (int n = 3; n <= 14; n++) begin
      step(1, 0, 0, 0, 0);
      if (n >= 5) check("saw_seq", O_data, saw_tab[(n - 5) % 4]);
      check("saw_wrap", O_wrap, (n >= 6) && ((n - 6) % 4 == 0));
    end

    // Square at half amplitude, handed over at the next wrap
    step(1, 1, 64'h4000_0000, 2, 128);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0);

    // Mid-period offer of a triangle
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (!m_pend && m_phase == 64'h4000_0000) found = 1;
      else step(1, 0, 0, 0, 0);
    end
    if (!found) bound_expired("mid_period");
    step(1, 1, 64'h4000_0000, 1, 200);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);

    // Offer landing on the exact carry-out edge
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (!m_pend && (m_phase + m_ftw >= MOD)) found = 1;
      else step(1, 0, 0, 0, 0);
    end
    if (!found) bound_expired("carry_offer");
    step(1, 1, 64'h2000_0000, 0, 300);
    check("carry_offer_pending", I_cfg_ready, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);

    // Enable gap
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);

    // Reset while a config is pending
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (!m_pend && m_ftw != 0 && (m_phase + m_ftw < MOD)) found = 1;
      else step(1, 0, 0, 0, 0);
    end
    if (!found) bound_expired("pend_reset");
    step(1, 1, 64'h1234_5678, 0, 256);
    check("pend_before_rst", I_cfg_ready, 0);
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      step(1, 0, 0, 0, 0);
      check("post_rst_mid", O_data, MID);
      check("post_rst_valid", O_valid, n >= 3);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit en, vld;
      longint unsigned ftw;
      case ($urandom_range(0, 3))
        0: ftw = 0;
        1: ftw = longint'($urandom);
        2: ftw = longint'($urandom_range(1, 8)) << 28;
        default: ftw = longint'($urandom) >> 2;
      endcase
      en = ($urandom_range(0, 9) != 0);
      vld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      step(en, vld, ftw, int'($urandom_range(0, 3)), int'($urandom_range(0, 511)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
